// File: rtl/cart_pkg.sv
// Shared cart-handling types: scan sequencer states, bankswitch codes
// and the detector scan ceiling.
package cart_pkg;

   localparam int SCAN_MAX_DEF = 8192;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_FEED   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   typedef enum logic [3:0] {
      BS_NONE = 4'd0,
      BS_F8   = 4'd1,
      BS_F6   = 4'd2,
      BS_F4   = 4'd3,
      BS_E0   = 4'd4,
      BS_3F   = 4'd5,
      BS_CV   = 4'd9,
      BS_E7   = 4'd12
   } bs_t;

   // A nonzero extension-forced type always beats the detector.
   function automatic logic [3:0] resolve_bs(
      input logic [3:0] ext,
      input logic [3:0] det
   );
      return (ext != 4'd0) ? ext : det;
   endfunction

endpackage

// File: rtl/detect2600_scan_ctrl.sv
// Post-load sequencer: streams the cart image from memory into the
// bankswitch detector, then latches the resolved type and superchip flag.
module detect2600_scan_ctrl
   import cart_pkg::*;
#(
   parameter int SCAN_MAX = SCAN_MAX_DEF,
   parameter int SETTLE   = 4,
   parameter int SC_MIN   = 4225
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] rom_size,
   input  logic [3:0]  ext_bs,
   output logic        mem_req,
   output logic [12:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_dout,
   output logic [12:0] det_addr,
   output logic        det_enable,
   output logic [7:0]  det_data,
   input  logic [3:0]  det_force_bs,
   input  logic        det_sc,
   output logic        busy,
   output logic        done,
   output logic [3:0]  bs_type,
   output logic        sc_out
);

   localparam logic [13:0] N_MAX    = 14'(SCAN_MAX);
   localparam logic [31:0] N_MAX_W  = 32'(SCAN_MAX);
   localparam logic [7:0]  SET_LAST = 8'(SETTLE - 1);
   localparam logic [31:0] SC_MIN_W = 32'(SC_MIN);

   logic [2:0]  state;
   logic        pend;
   logic [13:0] idx;
   logic [13:0] n;
   logic [7:0]  cnt;
   logic [7:0]  byte_q;
   logic [12:0] addr_q;
   logic [3:0]  ext_q;
   logic [31:0] size_q;
   logic [3:0]  bs_q;
   logic        sc_q;

   logic [13:0] n_in;
   logic [13:0] idx_nx;
   logic [3:0]  bs_res;
   logic        sc_res;

   assign n_in   = (rom_size >= N_MAX_W) ? N_MAX : rom_size[13:0];
   assign idx_nx = idx + 14'd1;
   assign bs_res = resolve_bs(ext_q, det_force_bs);
   assign sc_res = det_sc && (size_q >= SC_MIN_W);

   assign mem_req    = (state == S_FETCH);
   assign mem_addr   = idx[12:0];
   assign det_enable = (state == S_FEED);
   assign det_addr   = addr_q;
   assign det_data   = byte_q;
   assign done       = (state == S_DONE);
   assign busy       = (state != S_IDLE) || pend;
   assign bs_type    = done ? bs_res : bs_q;
   assign sc_out     = done ? sc_res : sc_q;

   // A restart from a busy state parks one cycle in IDLE (pend) so
   // mem_req visibly drops before the new fetch begins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         pend   <= 1'b0;
         idx    <= '0;
         n      <= '0;
         cnt    <= '0;
         byte_q <= '0;
         addr_q <= '0;
         ext_q  <= '0;
         size_q <= '0;
         bs_q   <= '0;
         sc_q   <= 1'b0;
      end else if (start) begin
         ext_q  <= ext_bs;
         size_q <= rom_size;
         n      <= n_in;
         idx    <= '0;
         cnt    <= '0;
         if (state == S_DONE) begin
            bs_q <= bs_res;
            sc_q <= sc_res;
         end
         if (n_in == 14'd0) begin
            state <= S_SETTLE;
            pend  <= 1'b0;
         end else if (state == S_IDLE) begin
            state <= S_FETCH;
            pend  <= 1'b0;
         end else begin
            state <= S_IDLE;
            pend  <= 1'b1;
         end
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pend) begin
                  pend  <= 1'b0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  byte_q <= mem_dout;
                  addr_q <= idx[12:0];
                  state  <= S_FEED;
               end
            end
            S_FEED: begin
               idx   <= idx_nx;
               state <= (idx_nx == n) ? S_SETTLE : S_FETCH;
            end
            S_SETTLE: begin
               if (cnt == SET_LAST) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               bs_q  <= bs_res;
               sc_q  <= sc_res;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_detect2600_scan_ctrl.sv
// Scoreboard bench for detect2600_scan_ctrl with a random-latency memory
// and a small behavioural stand-in for the detect2600 detector.
module tb_detect2600_scan_ctrl;

   localparam int SETTLE = 4;
   localparam int SC_MIN = 4225;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] rom_size = '0;
   logic [3:0]  ext_bs = '0;
   logic        mem_req;
   logic [12:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_dout = '0;
   logic [12:0] det_addr;
   logic        det_enable;
   logic [7:0]  det_data;
   logic [3:0]  det_force_bs;
   logic        det_sc;
   logic        busy;
   logic        done;
   logic [3:0]  bs_type;
   logic        sc_out;

   always #5 clk = ~clk;

   detect2600_scan_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .rom_size(rom_size), .ext_bs(ext_bs),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_dout(mem_dout),
      .det_addr(det_addr), .det_enable(det_enable), .det_data(det_data),
      .det_force_bs(det_force_bs), .det_sc(det_sc),
      .busy(busy), .done(done), .bs_type(bs_type), .sc_out(sc_out)
   );

   typedef struct packed { logic [12:0] a; logic [7:0] d; } feed_t;
   typedef struct packed { logic [3:0] bs; logic sc; } res_t;

   feed_t  fq[$];
   res_t   rq[$];
   int     total = 0;
   int     bad = 0;
   logic [7:0] image [0:8191];
   int     lat_min = 1;
   int     lat_max = 1;
   int     lat_cur = 1;
   int     wait_cnt = 0;
   logic   inject_ack = 1'b0;
   logic   sc_drive = 1'b0;
   longint cyc = 0;
   longint evt_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit sig(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c);
      return (a == 8'h8D && b == 8'hE0 && c == 8'h1F) ||
             (a == 8'hAD && b == 8'hE9 && c == 8'hFF);
   endfunction

   // Detector stand-in: E0 hotspot pattern seen and the image is a full 8K.
   logic [7:0]  w0, w1;
   logic        hit;
   logic [12:0] last_a;
   logic [3:0]  p1, p2;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w0 <= '0; w1 <= '0; hit <= 1'b0; last_a <= '0; p1 <= '0; p2 <= '0;
      end else begin
         if (det_enable) begin
            last_a <= det_addr;
            w0 <= det_data;
            if (det_addr == 13'd0) begin
               w1 <= '0;
               hit <= 1'b0;
            end else begin
               w1 <= w0;
               if (sig(w1, w0, det_data)) hit <= 1'b1;
            end
         end
         p1 <= (hit && last_a == 13'd8191) ? 4'd4 : 4'd0;
         p2 <= p1;
      end
   end
   assign det_force_bs = p2;
   assign det_sc = sc_drive;

   // Memory responder with per-read random latency.
   always @(posedge clk) begin
      #1;
      mem_ack = 1'b0;
      if (inject_ack) begin
         mem_ack = 1'b1;
         mem_dout = 8'hEE;
         inject_ack = 1'b0;
         wait_cnt = 0;
      end else if (mem_req) begin
         if (wait_cnt + 1 >= lat_cur) begin
            mem_ack = 1'b1;
            mem_dout = image[mem_addr];
            wait_cnt = 0;
            lat_cur = $urandom_range(lat_max, lat_min);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Monitor: pops expected bytes on each enable, results on each done.
   always @(negedge clk) begin
      if (reset_n) begin
         if (det_enable) begin
            if (fq.size() == 0) begin
               chk("stray_enable", det_enable, 0);
            end else begin
               feed_t f;
               f = fq.pop_front();
               chk("det_addr", det_addr, f.a);
               chk("det_data", det_data, f.d);
            end
            evt_cyc = cyc;
         end
         if (done) begin
            if (rq.size() == 0) begin
               chk("stray_done", done, 0);
            end else begin
               res_t r;
               r = rq.pop_front();
               chk("bs_type", bs_type, r.bs);
               chk("sc_out", sc_out, r.sc);
               chk("unfed_bytes", fq.size(), 0);
               chk("done_delay", cyc - evt_cyc, SETTLE + 1);
            end
         end
      end
   end

   function automatic res_t ref_res(input int size, input logic [3:0] ext,
                                    input logic sc);
      res_t r;
      int n;
      bit found;
      n = (size > 8192) ? 8192 : size;
      found = 0;
      for (int i = 0; i + 2 < n; i++)
         if (sig(image[i], image[i+1], image[i+2])) found = 1;
      r.bs = (ext != 4'd0) ? ext : ((found && n == 8192) ? 4'd4 : 4'd0);
      r.sc = sc && (size >= SC_MIN);
      return r;
   endfunction

   task automatic issue(input int size, input logic [3:0] ext, input logic sc);
      int n;
      n = (size > 8192) ? 8192 : size;
      sc_drive = sc;
      for (int i = 0; i < n; i++) fq.push_back('{a: 13'(i), d: image[i]});
      rq.push_back(ref_res(size, ext, sc));
      rom_size = 32'(size);
      ext_bs = ext;
      start = 1'b1;
      evt_cyc = cyc;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_res(input int limit);
      int k;
      k = 0;
      while (rq.size() != 0 && k < limit) begin
         @(posedge clk); #2;
         k++;
      end
      chk("result_timeout", rq.size(), 0);
      rq.delete();
      fq.delete();
      @(posedge clk); #2;
   endtask

   task automatic put_sig(input int off, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c);
      image[off] = a;
      image[off+1] = b;
      image[off+2] = c;
   endtask

   task automatic fill_image();
      for (int i = 0; i < 8192; i++) image[i] = 8'($urandom);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_image();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_det_enable", det_enable, 0);
      chk("rst_det_addr", det_addr, 0);
      chk("rst_det_data", det_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bs_type", bs_type, 0);
      chk("rst_sc_out", sc_out, 0);
      reset_n = 1'b1;
      @(posedge clk); #2;

      // 4K image with an E0 pattern: not 8K, so no E0 result.
      put_sig($urandom_range(4000, 1), 8'h8D, 8'hE0, 8'h1F);
      lat_min = 1; lat_max = 1; lat_cur = 1;
      issue(4096, 4'd0, 1'b1);
      chk("busy_scan", busy, 1);
      wait_res(20000);

      // Full 8K with the second E0 pattern and random ack latency.
      fill_image();
      put_sig($urandom_range(8000, 4096), 8'hAD, 8'hE9, 8'hFF);
      lat_min = 1; lat_max = 2;
      issue(8192, 4'd0, 1'b1);
      wait_res(40000);

      // Extension override wins over a detected E0.
      lat_min = 1; lat_max = 1; lat_cur = 1;
      put_sig($urandom_range(8000, 10), 8'h8D, 8'hE0, 8'h1F);
      issue(8192, 4'd2, 1'b0);
      wait_res(20000);

      // Oversized image: only the first 8K is streamed.
      issue(16384, 4'd0, 1'b1);
      wait_res(20000);

      // Smallest size for which the superchip flag is trusted.
      issue(SC_MIN, 4'd0, 1'b1);
      wait_res(12000);

      // Empty image, with an ack arriving outside FETCH.
      issue(0, 4'd7, 1'b1);
      inject_ack = 1'b1;
      for (int i = 0; i < SETTLE; i++) begin
         chk("no_req_empty", mem_req, 0);
         @(posedge clk); #2;
      end
      wait_res(50);

      // Single byte image.
      issue(1, 4'd0, 1'b0);
      wait_res(50);

      for (int t = 0; t < 6; t++) begin
         int sz;
         logic [3:0] ex;
         logic s;
         sz = $urandom_range(300, 1);
         ex = ($urandom_range(1, 0) != 0) ? 4'($urandom_range(15, 1)) : 4'd0;
         s = 1'($urandom_range(1, 0));
         lat_min = 1; lat_max = 4;
         issue(sz, ex, s);
         wait_res(3000);
      end

      // Restart at byte 100 with a stale ack alongside the new start.
      lat_min = 1; lat_max = 1; lat_cur = 1;
      if (image[0] == 8'hEE) image[0] = 8'h11;
      issue(400, 4'd3, 1'b0);
      begin
         int k;
         k = 0;
         while (!(mem_req && mem_addr == 13'd100) && k < 2000) begin
            @(posedge clk); #2;
            k++;
         end
         chk("restart_reached", mem_addr, 100);
      end
      fq.delete();
      rq.delete();
      inject_ack = 1'b1;
      issue(300, 4'd5, 1'b1);
      chk("restart_gap_req", mem_req, 0);
      chk("restart_busy", busy, 1);
      wait_res(3000);

      // Reset in mid-scan clears the held result.
      issue(200, 4'd0, 1'b0);
      repeat (50) @(posedge clk);
      #2;
      reset_n = 1'b0;
      fq.delete();
      rq.delete();
      #1;
      chk("mid_rst_bs_type", bs_type, 0);
      chk("mid_rst_sc_out", sc_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mem_req", mem_req, 0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #2;
      issue(20, 4'd9, 1'b0);
      wait_res(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
